// File: rtl/dff_bank_arbiter.sv
// Shared WIDTH-bit register written by N_REQ round-robin requesters.
// Define STICKY_GRANT_EN to let a winner hold the grant for up to MAX_BURST edges.
module dff_bank_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                   valid,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       q_bar
);

    localparam int OW = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic [OW-1:0]    last;
    logic [OW-1:0]    rr_idx;
    logic [OW-1:0]    cand;
    logic             rr_found;
    logic [OW-1:0]    win;
    logic [WIDTH-1:0] lane;

    // First active requester after the previous winner, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = OW'((int'(last) + k) % N_REQ);
            if (!rr_found && req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

`ifdef STICKY_GRANT_EN
    logic [3:0] burst;
    logic       sticky;

    // burst == 0 means no grant is in progress (after reset or idle).
    assign sticky = (burst != 4'd0)
                 && (burst < 4'(MAX_BURST))
                 && req[last];
    assign win    = sticky ? last : rr_idx;
`else
    assign win = rr_idx;
`endif

    always_comb begin
        lane = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == OW'(i)) begin
                lane = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt   <= '0;
            owner <= '0;
            valid <= 1'b0;
            q     <= '0;
            last  <= OW'(N_REQ - 1);
`ifdef STICKY_GRANT_EN
            burst <= 4'd0;
`endif
        end else if (|req) begin
            gnt   <= ONE << win;
            owner <= win;
            valid <= 1'b1;
            q     <= lane;
            last  <= win;
`ifdef STICKY_GRANT_EN
            burst <= sticky ? burst + 4'd1 : 4'd1;
`endif
        end else begin
            gnt   <= '0;
            valid <= 1'b0;
`ifdef STICKY_GRANT_EN
            burst <= 4'd0;
`endif
        end
    end

    assign q_bar = ~q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Randomized and directed bench for dff_bank_arbiter against a queue-free
// behavioural model of the grant rules; honours STICKY_GRANT_EN.
module tb_dff_bank_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [1:0]     owner;
    logic           valid;
    logic [W-1:0]   q;
    logic [W-1:0]   q_bar;

    int n_cmp  = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // reference model state
    int           m_last;
    int           m_burst;
    logic [N-1:0] m_gnt;
    int           m_owner;
    logic         m_valid;
    logic [W-1:0] m_q;

    dff_bank_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .owner(owner), .valid(valid), .q(q), .q_bar(q_bar)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (!$onehot0(gnt)) begin
                n_fail++;
                $display("FAIL onehot0: gnt=%b", gnt);
            end
            n_cmp++;
            if (q_bar !== ~q) begin
                n_fail++;
                $display("FAIL qbar: q_bar=%h required %h", q_bar, ~q);
            end
        end
    end

    function automatic int rr_pick(input logic [N-1:0] r, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (r[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic r_rst, input logic [N-1:0] r,
                              input logic [N*W-1:0] d);
        int w;
        if (r_rst) begin
            m_gnt = '0; m_owner = 0; m_valid = 1'b0; m_q = '0;
            m_last = N - 1; m_burst = 0;
        end else if (r == '0) begin
            m_gnt = '0; m_valid = 1'b0; m_burst = 0;
        end else begin
`ifdef STICKY_GRANT_EN
            if (m_burst > 0 && m_burst < MB && r[m_last]) begin
                w = m_last;
                m_burst++;
            end else begin
                w = rr_pick(r, m_last);
                m_burst = 1;
            end
`else
            w = rr_pick(r, m_last);
`endif
            m_gnt = '0;
            m_gnt[w] = 1'b1;
            m_owner = w;
            m_valid = 1'b1;
            m_q = d[w*W +: W];
            m_last = w;
        end
    endtask

    task automatic tick(input logic r_rst, input logic [N-1:0] r,
                        input logic [N*W-1:0] d);
        @(negedge clk);
        rst = r_rst; req = r; wdata = d;
        @(posedge clk);
        model_step(r_rst, r, d);
        #1;
    endtask

    task automatic test_reset;
        tick(1'b1, 4'b1111, {4{8'hEE}});
        mon_en = 1'b1;
        n_cmp++;
        if (gnt !== 4'b0000 || owner !== 2'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: gnt=%b owner=%0d valid=%b required 0000/0/0",
                     gnt, owner, valid);
        end
        n_cmp++;
        if (q !== 8'h00 || q_bar !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_q: q=%h q_bar=%h required 00/ff", q, q_bar);
        end
    endtask

    task automatic test_single_and_idle;
        tick(1'b1, 4'b0000, '0);
        tick(1'b0, 4'b0100, {8'h11, 8'hA5, 8'h22, 8'h33});
        n_cmp++;
        if (gnt !== 4'b0100 || owner !== 2'd2 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ctl: gnt=%b owner=%0d valid=%b required 0100/2/1",
                     gnt, owner, valid);
        end
        n_cmp++;
        if (q !== 8'hA5 || q_bar !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_q: q=%h q_bar=%h required a5/5a", q, q_bar);
        end
        tick(1'b0, 4'b0000, {4{8'h77}});
        n_cmp++;
        if (gnt !== 4'b0000 || valid !== 1'b0 || q !== 8'hA5 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL idle_hold: gnt=%b valid=%b q=%h owner=%0d required 0000/0/a5/2",
                     gnt, valid, q, owner);
        end
    endtask

    task automatic test_rotation;
        logic [N*W-1:0] d;
        logic [N-1:0] exp_g;
        d = {8'h43, 8'h32, 8'h21, 8'h10};
        tick(1'b1, 4'b0000, '0);
`ifdef STICKY_GRANT_EN
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 4'b1111, d);
            exp_g = (i < 4) ? 4'b0001 : 4'b0010;
            n_cmp++;
            if (gnt !== exp_g || q !== d[(i / 4)*W +: W]) begin
                n_fail++;
                $display("FAIL sticky_seq[%0d]: gnt=%b q=%h required %b/%h",
                         i, gnt, q, exp_g, d[(i / 4)*W +: W]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 4'b0001, d);
            n_cmp++;
            if (gnt !== 4'b0001 || q !== 8'h10) begin
                n_fail++;
                $display("FAIL sticky_solo[%0d]: gnt=%b q=%h required 0001/10",
                         i, gnt, q);
            end
        end
`else
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 4'b1111, d);
            exp_g = 4'b0001 << (i % 4);
            n_cmp++;
            if (gnt !== exp_g || q !== d[(i % 4)*W +: W]) begin
                n_fail++;
                $display("FAIL rr_seq[%0d]: gnt=%b q=%h required %b/%h",
                         i, gnt, q, exp_g, d[(i % 4)*W +: W]);
            end
        end
`endif
    endtask

    task automatic test_drop_head;
        tick(1'b1, 4'b0000, '0);
        tick(1'b0, 4'b0001, {8'h44, 8'h33, 8'h22, 8'h11});
        tick(1'b0, 4'b1100, {8'h44, 8'h33, 8'h22, 8'h11});
        n_cmp++;
        if (gnt !== 4'b0100 || q !== 8'h33) begin
            n_fail++;
            $display("FAIL drop_head: gnt=%b q=%h required 0100/33", gnt, q);
        end
    endtask

    task automatic test_reset_midburst;
        bit seen;
        seen = 1'b0;
        tick(1'b1, 4'b0000, '0);
        for (int i = 0; i < 12 && !seen; i++) begin
            tick(1'b0, 4'b1111, {8'hD4, 8'hC3, 8'hB2, 8'hA1});
            if (gnt === 4'b0010) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midburst_wait: gnt=%b never reached required 0010", gnt);
        end
        tick(1'b1, 4'b1111, {8'hD4, 8'hC3, 8'hB2, 8'hA1});
        n_cmp++;
        if (gnt !== 4'b0000 || q !== 8'h00 || q_bar !== 8'hFF || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midburst_rst: gnt=%b q=%h q_bar=%h valid=%b required 0000/00/ff/0",
                     gnt, q, q_bar, valid);
        end
        tick(1'b0, 4'b1111, {8'hD4, 8'hC3, 8'hB2, 8'hA1});
        n_cmp++;
        if (gnt !== 4'b0001 || q !== 8'hA1) begin
            n_fail++;
            $display("FAIL post_rst: gnt=%b q=%h required 0001/a1", gnt, q);
        end
    endtask

    task automatic test_random;
        logic [N-1:0]   r;
        logic [N*W-1:0] d;
        logic           rr;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            d  = {$urandom, $urandom} [N*W-1:0];
            rr = ($urandom_range(0, 39) == 0);
            tick(rr, r, d);
            n_cmp++;
            if (gnt !== m_gnt || owner !== 2'(m_owner)) begin
                n_fail++;
                $display("FAIL rand_gnt[%0d]: gnt=%b owner=%0d required %b/%0d",
                         i, gnt, owner, m_gnt, m_owner);
            end
            n_cmp++;
            if (q !== m_q || valid !== m_valid) begin
                n_fail++;
                $display("FAIL rand_q[%0d]: q=%h valid=%b required %h/%b",
                         i, q, valid, m_q, m_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; wdata = '0;
        test_reset;
        test_single_and_idle;
        test_rotation;
        test_drop_head;
        test_reset_midburst;
        test_random;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing the register (2..8).
REQ-002 Parameter: WIDTH, 8, width of the shared D-flip-flop register.
REQ-003 Parameter: MAX_BURST, 4, maximum consecutive grants to one requester when sticky grant is compiled in (1..15).
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: req  input  N_REQ  per-requester write request, bit i = requester i.
REQ-007 Port: wdata  input  N_REQ*WIDTH  write data; lane i = bits [i*WIDTH +: WIDTH].
REQ-008 Port: gnt  output  N_REQ  registered one-hot grant, or all-zero when idle.
REQ-009 Port: owner  output  clog2(N_REQ)  registered index of the current grantee.
REQ-010 Port: valid  output  1  high for the cycle after a grant edge, i.e. q was written at the last edge.
REQ-011 Port: q  output  WIDTH  shared register contents.
REQ-012 Port: q_bar  output  WIDTH  bitwise complement of q at all times.

Function
REQ-013 The block SHALL evaluate req every rising edge of clk and select at most one winner w.
REQ-014 Selection SHALL be round-robin: search starts at index (last+1) mod N_REQ and wraps; last = most recent winner.
REQ-015 On an edge with a winner: gnt <= onehot(w), owner <= w, q <= wdata lane w, valid <= 1, last <= w.
REQ-016 On an edge with req == 0: gnt <= 0, valid <= 0; q, owner and last SHALL hold.
REQ-017 Latency: req asserted before edge k SHALL produce gnt, q, valid at edge k (one cycle from req to q).
REQ-018 gnt SHALL never have more than one bit set; q_bar SHALL equal ~q in every cycle, including reset.
REQ-019 A requester that drops req SHALL NOT be granted at the next edge, even if it is at the head of the rotation.
REQ-020 wdata lanes of non-winning requesters SHALL have no effect on q.

Reset
REQ-021 With rst high at an edge: gnt = 0, owner = 0, valid = 0, q = 0, q_bar = all ones, burst counter = 0, last = N_REQ-1, so requester 0 has first priority.
REQ-022 rst SHALL take precedence over any req at the same edge, including mid-burst; the grant in progress is abandoned with no partial write.

Configuration
REQ-023 Macro STICKY_GRANT_EN SHALL select the grant policy.
REQ-024 With STICKY_GRANT_EN defined: if the previous winner still requests and its burst count < MAX_BURST, it SHALL win again and the counter SHALL increment.
REQ-025 Under STICKY_GRANT_EN: at MAX_BURST, the grant SHALL rotate to the next requester per REQ-014 if any other requester is active; otherwise the same requester is re-granted and the counter restarts at 1.
REQ-026 Under STICKY_GRANT_EN: the counter SHALL reset to 1 on any change of winner and to 0 on an idle edge.
REQ-027 Without STICKY_GRANT_EN: strict per-cycle round-robin per REQ-014; no burst counter is built.

Verification (N_REQ=4, WIDTH=8, MAX_BURST=4)
REQ-028 Reset then req=4'b0100, lane2=8'hA5 -> next edge: gnt=0100, owner=2, q=8'hA5, q_bar=8'h5A, valid=1.
REQ-029 Without sticky grant, req=4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001; q follows lanes 0, 1, 2, 3, 0.
REQ-030 With sticky grant, req=4'b1111 held -> gnt=0001 for 4 edges, then 0010 for 4 edges; with only req=4'b0001, gnt=0001 indefinitely.
REQ-031 After q=8'hA5, req=0 -> gnt=0000, valid=0, q stays 8'hA5.
REQ-032 rst pulsed while gnt=0010 and req=1111 -> next edge gnt=0, q=8'h00, q_bar=8'hFF; after release, first grant is 0001.
REQ-033 Throughout all scenarios, the checker SHALL assert onehot0(gnt) and q_bar == ~q every cycle.
